// File: rtl/spi_cfg_seq_if.sv
// -----------------------------------------------------------------------------
// spi_cfg_seq_if
//
// System-bus link between the configuration sequencer and the SB_SPI hard IP
// register port.
//
// Signals:
//   sb_adr  [7:0]  register address           (master -> slave, SBADRi)
//   sb_dat  [7:0]  write data                 (master -> slave, SBDATi)
//   sb_we          write enable               (master -> slave, SBWRi)
//   sb_stb         bus strobe                 (master -> slave, SBSTBi)
//   sb_ack         acknowledge                (slave -> master, SBACKo)
// -----------------------------------------------------------------------------
interface spi_cfg_seq_if;
    logic [7:0] sb_adr;
    logic [7:0] sb_dat;
    logic       sb_we;
    logic       sb_stb;
    logic       sb_ack;

    modport master (
        output sb_adr,
        output sb_dat,
        output sb_we,
        output sb_stb,
        input  sb_ack
    );

    modport slave (
        input  sb_adr,
        input  sb_dat,
        input  sb_we,
        input  sb_stb,
        output sb_ack
    );
endinterface

// File: rtl/spi_cfg_seq.sv
// -----------------------------------------------------------------------------
// spi_cfg_seq
//
// Configuration sequencer for the SB_SPI hard IP. On a start pulse it walks a
// registered configuration ROM of {reg_addr[15:8], value[7:0]} entries and
// issues one system-bus register write per entry, stopping at the end-of-list
// marker (reg_addr == END_ADDR). A missing marker or an ack timeout ends the
// run with err set.
//
// Parameters:
//   MAX_ENTRIES  ROM depth scanned (<= 16, 4-bit ROM address)
//   END_ADDR     register address that terminates the list
//   ACK_TIMEOUT  strobe cycles to wait for sb_ack before aborting (8-bit)
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        one-cycle run request, honoured only when idle
//   rom_addr     registered ROM entry index
//   rom_data     ROM output, valid one cycle after rom_addr
//   sb           system-bus master (adr/dat/we/stb out, ack in)
//   busy         high whenever not idle
//   done         one-cycle pulse at the end of a run (success or error)
//   err          timeout or missing end marker; held until next start/rst
//   wr_count     acknowledged writes in the current or last run
// -----------------------------------------------------------------------------
module spi_cfg_seq #(
    parameter int unsigned MAX_ENTRIES = 16,
    parameter logic [7:0]  END_ADDR    = 8'hFF,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [3:0]    rom_addr,
    input  logic [15:0]   rom_data,
    spi_cfg_seq_if.master sb,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [4:0]    wr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StWrite,
        StFin,
        StErr
    } state_e;

    localparam logic [3:0] LastAddr = 4'(MAX_ENTRIES - 1);
    // Counter value at which the final allowed strobe cycle is reached; the
    // strobe drops at the end of that cycle, giving exactly ACK_TIMEOUT cycles.
    localparam logic [7:0] TmoLast  = 8'(ACK_TIMEOUT - 1);

    state_e state_q, state_d;

    logic [3:0] addr_q, addr_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       we_q, we_d;
    logic       stb_q, stb_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;

    logic is_end;
    logic tmo_hit;
    logic last_entry;

    assign is_end     = (rom_data[15:8] == END_ADDR);
    assign tmo_hit    = (tmo_q == TmoLast);
    assign last_entry = (addr_q == LastAddr);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                state_d = is_end ? StFin : StWrite;
            end
            StWrite: begin
                // An ack in the final timeout cycle still counts as a success.
                if (sb.sb_ack) begin
                    state_d = last_entry ? StErr : StFetch;
                end else if (tmo_hit) begin
                    state_d = StErr;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next-state logic (all outputs are registered)
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        we_d   = we_q;
        stb_d  = stb_q;
        done_d = 1'b0;
        err_d  = err_q;
        cnt_d  = cnt_q;
        tmo_d  = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d = 4'd0;
                    cnt_d  = 5'd0;
                    err_d  = 1'b0;
                end
            end
            StFetch: begin
                // ROM samples addr_q this cycle; nothing to update.
            end
            StLatch: begin
                if (!is_end) begin
                    adr_d = rom_data[15:8];
                    dat_d = rom_data[7:0];
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    tmo_d = 8'd0;
                end
            end
            StWrite: begin
                if (sb.sb_ack) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    cnt_d = cnt_q + 5'd1;
                    if (!last_entry) begin
                        addr_d = addr_q + 4'd1;
                    end
                end else if (tmo_hit) begin
                    // Abandon the write; it is not counted.
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StFin: begin
                done_d = 1'b1;
            end
            StErr: begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                stb_d = 1'b0;
                we_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath / output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 4'd0;
            adr_q  <= 8'd0;
            dat_q  <= 8'd0;
            we_q   <= 1'b0;
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= 5'd0;
            tmo_q  <= 8'd0;
        end else begin
            addr_q <= addr_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            we_q   <= we_d;
            stb_q  <= stb_d;
            done_q <= done_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_addr  = addr_q;
    assign sb.sb_adr = adr_q;
    assign sb.sb_dat = dat_q;
    assign sb.sb_we  = we_q;
    assign sb.sb_stb = stb_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wr_count  = cnt_q;
    // Decoded from the state register only, so no input reaches it.
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_cfg_seq.sv
module tb_spi_cfg_seq;

    localparam int unsigned AckTimeout = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  wr_count;

    spi_cfg_seq_if bus ();

    spi_cfg_seq #(
        .MAX_ENTRIES (16),
        .END_ADDR    (8'hFF),
        .ACK_TIMEOUT (AckTimeout)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sb       (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Registered ROM model: data valid one cycle after the address.
    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    logic [15:0] tbl [5] = '{16'h0700, 16'h0F01, 16'h0980, 16'h0A00, 16'h0B0B};

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    int cyc = 0;
    int go_cyc = 0;
    int k = 0;
    int stb_cnt, done_cnt, rise_cyc, fall_cyc, done_cyc, last_len, max_len, min_gap;
    int stb_cyc = 0;
    int wr_idx = 0;
    int ack_delay = 0;
    int never_idx = 0;
    bit never_en = 1'b0;
    bit ack_hold = 1'b0;
    bit stb_prev = 1'b0;
    bit prev_acked = 1'b0;
    bit have_fall = 1'b0;
    logic [7:0] cur_adr, cur_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle to the next falling edge, then run the bus model and
    // the strobe monitor / scoreboard on the settled outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_acked) wr_idx++;
        if (bus.sb_stb) begin
            if (!stb_prev) begin
                stb_cnt++;
                chk("sb_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("sb_adr_dat", {bus.sb_adr, bus.sb_dat}, exp_q.pop_front());
                chk("sb_we_rise", bus.sb_we, 1);
                if (have_fall) begin
                    if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
                    chk("stb_gap_ge2", 32'((cyc - fall_cyc) >= 2), 1);
                end
                rise_cyc = cyc;
                cur_adr  = bus.sb_adr;
                cur_dat  = bus.sb_dat;
            end else begin
                chk("sb_hold", {bus.sb_we, bus.sb_adr, bus.sb_dat}, {1'b1, cur_adr, cur_dat});
            end
            stb_cyc++;
        end else begin
            if (stb_prev) begin
                fall_cyc  = cyc;
                have_fall = 1'b1;
                last_len  = cyc - rise_cyc;
                if (last_len > max_len) max_len = last_len;
            end
            stb_cyc = 0;
        end
        stb_prev = bus.sb_stb;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        bus.sb_ack = ack_hold ||
                     (bus.sb_stb && stb_cyc == ack_delay + 1 && !(never_en && wr_idx == never_idx));
        prev_acked = bus.sb_stb && bus.sb_ack;
    endtask

    task automatic clear_mon();
        stb_cnt   = 0;
        done_cnt  = 0;
        max_len   = 0;
        min_gap   = 1000;
        have_fall = 1'b0;
        wr_idx    = 0;
        exp_q.delete();
    endtask

    // n entries from the fixed table (std) or a generated pattern, then FF00.
    task automatic load(input int n, input bit std);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFF00;
        for (int i = 0; i < n; i++) begin
            rom[i] = std ? tbl[i] : {8'(8'h20 + i), 8'(8'hA0 ^ i)};
            exp_q.push_back(rom[i]);
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        go_cyc = cyc;
        k = 1;
    endtask

    task automatic wait_done(input int budget);
        while (!done && k < budget) begin
            tick();
            k = cyc - go_cyc + 1;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_stb(input int budget);
        while (!bus.sb_stb && k < budget) begin
            tick();
            k = cyc - go_cyc + 1;
        end
        chk("stb_seen", bus.sb_stb, 1);
    endtask

    initial begin
        bus.sb_ack = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 16'hFF00;
        clear_mon();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_bus", {bus.sb_stb, bus.sb_we, bus.sb_adr, bus.sb_dat}, 0);
        rst = 1'b0;
        tick();

        // Five entries, ack two cycles after strobe
        clear_mon();
        ack_delay = 2;
        load(5, 1'b1);
        go();
        chk("busy_after_start", busy, 1);
        wait_stb(20);
        chk("first_stb_cycle", k, 3);
        wait_done(200);
        chk("t1_strobes", stb_cnt, 5);
        chk("t1_wr_count", wr_count, 5);
        chk("t1_err", err, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_stb_len", max_len, 3);
        chk("t1_queue_empty", exp_q.size(), 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_done_once", done_cnt, 1);

        // End marker at entry 0
        clear_mon();
        load(0, 1'b1);
        rom[0] = 16'hFF5A;
        go();
        wait_done(20);
        chk("t2_done_cycle", k, 4);
        chk("t2_strobes", stb_cnt, 0);
        chk("t2_wr_count", wr_count, 0);
        chk("t2_busy", busy, 0);
        tick();
        chk("t2_done_pulse", done, 0);

        // Third write never acked -> timeout
        clear_mon();
        ack_delay = 0;
        never_en  = 1'b1;
        never_idx = 2;
        load(5, 1'b1);
        go();
        wait_done(200);
        chk("t3_err", err, 1);
        chk("t3_wr_count", wr_count, 2);
        chk("t3_strobes", stb_cnt, 3);
        chk("t3_stb_len", last_len, AckTimeout);
        chk("t3_done_after_drop", done_cyc - fall_cyc, 1);
        chk("t3_rom_addr", rom_addr, 2);
        tick();
        chk("t3_err_held", err, 1);
        chk("t3_done_once", done_cnt, 1);

        // New start clears err and runs normally
        clear_mon();
        never_en = 1'b0;
        load(5, 1'b1);
        go();
        chk("t3b_err_cleared", err, 0);
        wait_done(200);
        chk("t3b_err", err, 0);
        chk("t3b_wr_count", wr_count, 5);

        // All 16 entries valid, immediate ack -> missing end marker
        clear_mon();
        ack_delay = 0;
        load(16, 1'b0);
        go();
        wait_done(200);
        chk("t4_strobes", stb_cnt, 16);
        chk("t4_wr_count", wr_count, 16);
        chk("t4_err", err, 1);
        chk("t4_rom_addr", rom_addr, 15);
        chk("t4_queue_empty", exp_q.size(), 0);

        // start pulsed during WRITE is ignored
        clear_mon();
        ack_delay = 2;
        load(5, 1'b1);
        go();
        wait_stb(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc - go_cyc + 1;
        wait_done(200);
        chk("t5_strobes", stb_cnt, 5);
        chk("t5_wr_count", wr_count, 5);
        chk("t5_err", err, 0);
        chk("t5_done_once", done_cnt, 1);
        tick();

        // rst during WRITE
        clear_mon();
        load(5, 1'b1);
        go();
        while (stb_cnt < 2 && k < 40) begin
            tick();
            k = cyc - go_cyc + 1;
        end
        chk("t5r_in_write", bus.sb_stb, 1);
        chk("t5r_wr_count_pre", wr_count, 1);
        rst = 1'b1;
        tick();
        chk("t5r_stb", bus.sb_stb, 0);
        chk("t5r_we", bus.sb_we, 0);
        chk("t5r_busy", busy, 0);
        chk("t5r_wr_count", wr_count, 0);
        chk("t5r_rom_addr", rom_addr, 0);
        rst = 1'b0;
        tick();
        chk("t5r_idle", busy, 0);

        // Ack held high: one write per 3 cycles
        clear_mon();
        ack_hold = 1'b1;
        load(5, 1'b1);
        go();
        wait_done(100);
        chk("t6_done_cycle", k, 19);
        chk("t6_strobes", stb_cnt, 5);
        chk("t6_wr_count", wr_count, 5);
        chk("t6_stb_len", max_len, 1);
        chk("t6_min_gap", min_gap, 2);
        chk("t6_err", err, 0);
        ack_hold = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
